// File: rtl/boron_stream_host.sv
// Byte-serial host front end for the Boron block cipher core: gathers 8 bytes, runs one core
// operation, streams the 64-bit result back out. Optional watchdog: BORON_HOST_TIMEOUT_EN.
module boron_stream_host #(
    parameter int Key_Bit_Size   = 80,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [Key_Bit_Size-1:0] key_in,
    input  logic                    key_load,
    input  logic                    enc_dec,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    core_start,
    output logic                    core_enc_dec,
    output logic [Key_Bit_Size-1:0] core_key,
    output logic [63:0]             core_text,
    input  logic [63:0]             core_result,
    input  logic                    core_done,
    output logic                    busy,
    output logic [15:0]             block_count,
    output logic                    timeout_err
);

    // state      | meaning
    // ST_COLLECT | accepting input bytes into the block register
    // ST_START   | one-cycle start pulse, core_* operands valid
    // ST_WAIT    | operands held, waiting for core_done
    // ST_EMIT    | streaming the 8 result bytes out, MSB first
    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_START,
        ST_WAIT,
        ST_EMIT
    } state_t;

    if (!(Key_Bit_Size == 80 || Key_Bit_Size == 128) || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("boron_stream_host: Key_Bit_Size must be 80 or 128 and TIMEOUT_CYCLES >= 2");
    end

    state_t                  state;
    logic [2:0]              in_idx;
    logic [2:0]              out_idx;
    logic [Key_Bit_Size-1:0] key_reg;
    logic [55:0]             block_reg;
    logic [63:0]             result_reg;
    logic                    accept;

    assign accept   = in_valid & in_ready;
    // result_reg shifts left one byte per transfer, so the current byte is always on top
    assign out_data = result_reg[63:56];

`ifdef BORON_HOST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_COLLECT;
            in_idx       <= 3'd0;
            out_idx      <= 3'd0;
            key_reg      <= '0;
            block_reg    <= '0;
            result_reg   <= '0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            core_start   <= 1'b0;
            core_enc_dec <= 1'b0;
            core_key     <= '0;
            core_text    <= '0;
            busy         <= 1'b0;
            block_count  <= '0;
`ifdef BORON_HOST_TIMEOUT_EN
            wd_cnt       <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            if (key_load) begin
                key_reg <= key_in;
            end
            core_start <= 1'b0;

            case (state)
                ST_COLLECT: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        block_reg <= {block_reg[47:0], in_data};
                        in_idx    <= in_idx + 3'd1;
                        if (in_idx == 3'd7) begin
                            // operands are snapshotted here so they are valid during START
                            in_ready     <= 1'b0;
                            core_start   <= 1'b1;
                            core_text    <= {block_reg, in_data};
                            core_key     <= key_reg;
                            core_enc_dec <= enc_dec;
                            busy         <= 1'b1;
                            state        <= ST_START;
                        end
                    end
                end

                ST_START: begin
`ifdef BORON_HOST_TIMEOUT_EN
                    wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
`endif
                    state  <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (core_done) begin
                        result_reg  <= core_result;
                        block_count <= block_count + 16'd1;
                        out_valid   <= 1'b1;
                        out_idx     <= 3'd0;
                        busy        <= 1'b0;
                        state       <= ST_EMIT;
                    end
`ifdef BORON_HOST_TIMEOUT_EN
                    else if (wd_cnt == '0) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        in_ready    <= 1'b1;
                        in_idx      <= 3'd0;
                        state       <= ST_COLLECT;
                    end else begin
                        wd_cnt <= wd_cnt - WD_W'(1);
                    end
`endif
                end

                ST_EMIT: begin
                    if (out_ready) begin
                        result_reg <= {result_reg[55:0], 8'h00};
                        out_idx    <= out_idx + 3'd1;
                        if (out_idx == 3'd7) begin
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            in_idx    <= 3'd0;
                            state     <= ST_COLLECT;
                        end
                    end
                end

                default: begin
                    state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boron_stream_host.sv
// Randomized bench for boron_stream_host with a stand-in cipher core and a block-level reference model.
module tb_boron_stream_host;

    localparam int KW = 80;
    localparam logic [63:0] CT0 = 64'h3cf72a8b7518e6f7;

    logic          clk = 1'b0;
    logic          reset;
    logic [KW-1:0] key_in;
    logic          key_load;
    logic          enc_dec;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          core_start;
    logic          core_enc_dec;
    logic [KW-1:0] core_key;
    logic [63:0]   core_text;
    logic [63:0]   core_result;
    logic          core_done;
    logic          busy;
    logic [15:0]   block_count;
    logic          timeout_err;

    int n_chk = 0;
    int n_bad = 0;

    logic [63:0]   exp_text;
    logic [KW-1:0] exp_key;
    logic          exp_mode;
    logic [KW-1:0] cur_key = '0;
    int            exp_count = 0;
    logic          core_en = 1'b1;
    logic          stale_req = 1'b0;
    int            fixed_lat = 0;

    boron_stream_host #(.Key_Bit_Size(KW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .key_in(key_in), .key_load(key_load), .enc_dec(enc_dec),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .core_start(core_start), .core_enc_dec(core_enc_dec), .core_key(core_key),
        .core_text(core_text), .core_result(core_result), .core_done(core_done),
        .busy(busy), .block_count(block_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stand-in cipher: an invertible keyed permutation anchored so that key 0 / block 0 gives CT0.
    function automatic logic [63:0] kmix(input logic [KW-1:0] k);
        logic [127:0] kk;
        kk = '0;
        kk[KW-1:0] = k;
        return kk[63:0] ^ kk[127:64];
    endfunction

    function automatic logic [63:0] ref_cipher(input logic [63:0] x, input logic [KW-1:0] k,
                                               input logic dec);
        logic [63:0] v;
        if (!dec) begin
            v = x ^ kmix(k);
            return {v[50:0], v[63:51]} ^ CT0;
        end
        v = x ^ CT0;
        return {v[12:0], v[63:13]} ^ kmix(k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Responder model of the core: random latency, checks operand snapshot and hold.
    initial begin : core_model
        logic [63:0]   t;
        logic [KW-1:0] k;
        logic          m;
        logic          done_prev;
        int            lat;
        core_done   = 1'b0;
        core_result = '0;
        done_prev   = 1'b0;
        forever begin
            tick();
            core_done = 1'b0;
            if (done_prev) chk("done_to_out_valid", out_valid, 1);
            done_prev = 1'b0;
            if (stale_req) begin
                core_result = 64'hdeadbeefcafef00d;
                core_done   = 1'b1;
                stale_req   = 1'b0;
            end else if (core_start && core_en && !reset) begin
                chk("start_text", core_text, exp_text);
                chk("start_key", core_key, exp_key);
                chk("start_mode", core_enc_dec, exp_mode);
                t = core_text;
                k = core_key;
                m = core_enc_dec;
                lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 6);
                for (int j = 0; j < lat; j++) begin
                    tick();
                    if (j == 0) chk("start_one_cycle", core_start, 0);
                end
                chk("hold_text", core_text, t);
                chk("hold_key", core_key, k);
                chk("hold_mode", core_enc_dec, m);
                chk("busy_wait", busy, 1);
                core_result = ref_cipher(t, k, m);
                core_done   = 1'b1;
                done_prev   = 1'b1;
            end
        end
    end

    task automatic do_key_load(input logic [KW-1:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        cur_key  = k;
    endtask

    task automatic send_bytes(input logic [63:0] pt, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int   guard;
            logic acc;
            guard = 0;
            acc   = 1'b0;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            in_data  = pt[63-8*i -: 8];
            in_valid = 1'b1;
            while (!acc && guard < 50) begin
                acc = in_ready;
                tick();
                guard++;
            end
            if (!acc) chk("send_accept_timeout", acc, 1);
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic recv_block(input logic [63:0] exp_ct, input int hold_at);
        int         got_n;
        int         cyc;
        int         held;
        logic [7:0] prev;
        logic       prev_stall;
        logic       rdy;
        got_n = 0;
        cyc = 0;
        held = 0;
        prev = 8'h00;
        prev_stall = 1'b0;
        while (got_n < 8 && cyc < 300) begin
            if (out_valid && got_n == hold_at && held < 5) begin
                rdy = 1'b0;
                held++;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            out_ready = rdy;
            if (out_valid) begin
                chk("in_ready_low_emit", in_ready, 0);
                if (prev_stall) chk("out_data_stable", out_data, prev);
                if (rdy) begin
                    chk("out_byte", out_data, exp_ct[63-8*got_n -: 8]);
                    got_n++;
                end
                prev_stall = !rdy;
                prev = out_data;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        chk("recv_count", got_n, 8);
        chk("in_ready_after_emit", in_ready, 1);
        chk("out_valid_after_emit", out_valid, 0);
    endtask

    task automatic setup_block(input logic [63:0] pt);
        exp_text = pt;
        exp_key  = cur_key;
        exp_mode = enc_dec;
    endtask

    task automatic run_block(input logic [63:0] pt, input logic [63:0] exp_ct, input int hold_at);
        setup_block(pt);
        send_bytes(pt, 8, 1'b1);
        chk("start_state", {core_start, busy, in_ready}, 3'b110);
        recv_block(exp_ct, hold_at);
        exp_count++;
        chk("block_count", block_count, exp_count);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {in_ready, out_valid, out_data, core_start, core_enc_dec, busy,
                             block_count, timeout_err}, 0);
        chk({tag, "_core"}, {core_key, core_text}, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_watchdog bench did not complete");
        $fatal(1);
    end

    initial begin : main
        logic [63:0] pt;
        logic [KW-1:0] kb;
        reset     = 1'b1;
        key_in    = '0;
        key_load  = 1'b0;
        enc_dec   = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset_init");
        reset = 1'b0;
        tick();

        // known encrypt and decrypt vectors
        do_key_load('0);
        enc_dec = 1'b0;
        run_block(64'h0, CT0, -1);
        enc_dec = 1'b1;
        run_block(CT0, 64'h0, -1);

        // backpressure in the middle of the output burst
        do_key_load({16'h1234, 64'h0f1e2d3c4b5a6978});
        enc_dec = 1'b0;
        pt = {$urandom, $urandom};
        run_block(pt, ref_cipher(pt, cur_key, 1'b0), 3);

        // randomized blocks
        for (int b = 0; b < 10; b++) begin
            if ($urandom_range(0, 2) == 0) begin
                kb = KW'({$urandom, $urandom, $urandom});
                do_key_load(kb);
            end
            enc_dec = 1'($urandom);
            pt = {$urandom, $urandom};
            run_block(pt, ref_cipher(pt, cur_key, enc_dec), $urandom_range(0, 8));
        end

        // key_load in the START cycle must only affect the next block
        enc_dec = 1'b0;
        pt = {$urandom, $urandom};
        setup_block(pt);
        send_bytes(pt, 8, 1'b0);
        chk("start_state_k1", core_start, 1);
        do_key_load({16'haaaa, 64'h5555aaaa5555aaaa});
        recv_block(ref_cipher(pt, exp_key, 1'b0), -1);
        exp_count++;
        chk("block_count_k1", block_count, exp_count);

        // key_load in the middle of WAIT
        fixed_lat = 6;
        pt = {$urandom, $urandom};
        setup_block(pt);
        send_bytes(pt, 8, 1'b1);
        repeat (2) tick();
        chk("busy_mid_wait", busy, 1);
        do_key_load({16'h0bad, 64'h0123456789abcdef});
        recv_block(ref_cipher(pt, exp_key, 1'b0), -1);
        exp_count++;
        fixed_lat = 0;
        pt = {$urandom, $urandom};
        run_block(pt, ref_cipher(pt, cur_key, 1'b0), -1);

        // reset after 4 input bytes, then a stale core_done
        enc_dec = 1'b1;
        send_bytes(64'h1122334455667788, 4, 1'b0);
        reset = 1'b1;
        tick();
        check_reset_outputs("reset_mid");
        reset = 1'b0;
        cur_key = '0;
        exp_count = 0;
        stale_req = 1'b1;
        repeat (4) tick();
        chk("stale_done_ignored", {out_valid, busy, block_count}, 0);
        enc_dec = 1'b0;
        run_block(64'h0, CT0, -1);

`ifdef BORON_HOST_TIMEOUT_EN
        // core never answers: watchdog abandons the block after 16 WAIT cycles
        core_en = 1'b0;
        pt = {$urandom, $urandom};
        setup_block(pt);
        send_bytes(pt, 8, 1'b0);
        repeat (16) tick();
        chk("timeout_not_yet", {timeout_err, busy}, 2'b01);
        tick();
        chk("timeout_fired", {timeout_err, busy, in_ready, out_valid}, 4'b1010);
        chk("timeout_count", block_count, exp_count);
        repeat (3) tick();
        chk("timeout_no_output", out_valid, 0);
        core_en = 1'b1;
        pt = {$urandom, $urandom};
        run_block(pt, ref_cipher(pt, cur_key, 1'b0), -1);
        chk("timeout_sticky", timeout_err, 1);
`else
        chk("timeout_tied", timeout_err, 0);
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
